// File: rtl/drw_pkg.sv
// Shared definitions for the drawing-engine VRAM read-port arbiter.
package drw_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_ADDR = 2'd1,
    ARB_DATA = 2'd2
  } arb_state_t;

  localparam logic [2:0] ARSIZE_4B    = 3'b010;
  localparam logic [1:0] RRESP_OKAY   = 2'b00;
  localparam logic [1:0] RRESP_SLVERR = 2'b10;

endpackage

// File: rtl/drw_rd_arb_pick.sv
// Round-robin grant selector with a last-owner register.
// Only built when DRW_RD_ARB_RR_EN is defined; the default build uses
// fixed priority inline in drw_axi_rd_arb.
`ifdef DRW_RD_ARB_RR_EN
module drw_rd_arb_pick (
  input  logic i_clk,
  input  logic i_arst,
  input  logic i_srst,
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_take,
  output logic o_pick
);

  logic r_last;

  // On contention favour the master that did not own the previous transaction
  always_comb begin
    o_pick = 1'b0;
    if (i_req0 && i_req1) o_pick = ~r_last;
    else if (i_req1)      o_pick = 1'b1;
  end

  // Last owner resets to 1 so master 0 wins the first contended grant
  always_ff @(posedge i_clk or posedge i_arst) begin
    if (i_arst)      r_last <= 1'b1;
    else if (i_srst) r_last <= 1'b1;
    else if (i_take) r_last <= o_pick;
  end

endmodule
`endif

// File: rtl/drw_axi_rd_arb.sv
// Two-master arbiter for the single VRAM AXI read port.
// Master 0: display read engine, master 1: drawing VRAM read controller.
// One outstanding transaction; R beats are steered to the owner until RLAST.
// Optional macro DRW_RD_ARB_RR_EN selects round-robin instead of fixed priority.
module drw_axi_rd_arb
  import drw_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              ACLK,
  input  logic              ARST,
  input  logic              RST,
  input  logic              M0_ARVALID,
  input  logic [ADDR_W-1:0] M0_ARADDR,
  input  logic [LEN_W-1:0]  M0_ARLEN,
  output logic              M0_ARREADY,
  output logic              M0_RVALID,
  output logic              M0_RLAST,
  output logic [DATA_W-1:0] M0_RDATA,
  input  logic              M0_RREADY,
  input  logic              M1_ARVALID,
  input  logic [ADDR_W-1:0] M1_ARADDR,
  input  logic [LEN_W-1:0]  M1_ARLEN,
  output logic              M1_ARREADY,
  output logic              M1_RVALID,
  output logic              M1_RLAST,
  output logic [DATA_W-1:0] M1_RDATA,
  input  logic              M1_RREADY,
  output logic              S_ARVALID,
  output logic [ADDR_W-1:0] S_ARADDR,
  output logic [LEN_W-1:0]  S_ARLEN,
  output logic [2:0]        S_ARSIZE,
  input  logic              S_ARREADY,
  input  logic              S_RVALID,
  input  logic              S_RLAST,
  input  logic [DATA_W-1:0] S_RDATA,
  input  logic [1:0]        S_RRESP,
  output logic              S_RREADY,
  output logic              GNT,
  output logic              BUSY,
  output logic              ERR
);

  arb_state_t       r_state;
  arb_state_t       w_next;
  logic             r_gnt;
  logic             r_err;
  logic [LEN_W-1:0] r_len;
  logic [LEN_W:0]   r_cnt;
  logic             w_any_req;
  logic             w_pick;
  logic             w_rready_sel;
  logic             w_r_hs;
  logic             w_ar_hs;
  logic             w_len_match;
  logic             w_beat_err;

  assign w_any_req    = M0_ARVALID | M1_ARVALID;
  assign w_rready_sel = r_gnt ? M1_RREADY : M0_RREADY;
  assign w_ar_hs      = (r_state == ARB_ADDR) && S_ARREADY;
  assign w_r_hs       = (r_state == ARB_DATA) && S_RVALID && w_rready_sel;
  assign w_len_match  = (r_cnt == {1'b0, r_len});
  assign w_beat_err   = ((S_RRESP & RRESP_SLVERR) != 2'b00) ||
                        ( S_RLAST && !w_len_match) ||
                        (!S_RLAST &&  w_len_match);

`ifdef DRW_RD_ARB_RR_EN
  logic w_take;
  assign w_take = (r_state == ARB_IDLE) && w_any_req;

  drw_rd_arb_pick u_pick (
    .i_clk  (ACLK),
    .i_arst (ARST),
    .i_srst (RST),
    .i_req0 (M0_ARVALID),
    .i_req1 (M1_ARVALID),
    .i_take (w_take),
    .o_pick (w_pick)
  );
`else
  // Fixed priority: only consulted when some request is present
  assign w_pick = ~M0_ARVALID;
`endif

  // State register
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST)     r_state <= ARB_IDLE;
    else if (RST) r_state <= ARB_IDLE;
    else          r_state <= w_next;
  end

  // Grant/length latch, beat counter and sticky error
  always_ff @(posedge ACLK or posedge ARST) begin
    if (ARST) begin
      r_gnt <= 1'b0;
      r_len <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else if (RST) begin
      r_gnt <= 1'b0;
      r_len <= '0;
      r_cnt <= '0;
      r_err <= 1'b0;
    end else begin
      if ((r_state == ARB_IDLE) && w_any_req) begin
        r_gnt <= w_pick;
        r_len <= w_pick ? M1_ARLEN : M0_ARLEN;
      end
      if (w_ar_hs) r_cnt <= '0;
      if (w_r_hs) begin
        r_cnt <= r_cnt + {{LEN_W{1'b0}}, 1'b1};
        if (w_beat_err) r_err <= 1'b1;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ARB_IDLE: if (w_any_req)           w_next = ARB_ADDR;
      ARB_ADDR: if (S_ARREADY)           w_next = ARB_DATA;
      ARB_DATA: if (w_r_hs && S_RLAST)   w_next = ARB_IDLE;
      default:                           w_next = ARB_IDLE;
    endcase
  end

  // Output steering per state
  always_comb begin
    S_ARVALID  = 1'b0;
    S_RREADY   = 1'b0;
    M0_ARREADY = 1'b0;
    M1_ARREADY = 1'b0;
    M0_RVALID  = 1'b0;
    M1_RVALID  = 1'b0;
    M0_RLAST   = 1'b0;
    M1_RLAST   = 1'b0;
    S_ARADDR   = r_gnt ? M1_ARADDR : M0_ARADDR;
    S_ARLEN    = r_gnt ? M1_ARLEN  : M0_ARLEN;
    S_ARSIZE   = ARSIZE_4B;
    M0_RDATA   = S_RDATA;
    M1_RDATA   = S_RDATA;
    GNT        = r_gnt;
    BUSY       = (r_state != ARB_IDLE);
    ERR        = r_err;
    case (r_state)
      ARB_ADDR: begin
        S_ARVALID  = 1'b1;
        M0_ARREADY = !r_gnt && S_ARREADY;
        M1_ARREADY =  r_gnt && S_ARREADY;
      end
      ARB_DATA: begin
        S_RREADY  = w_rready_sel;
        M0_RVALID = !r_gnt && S_RVALID;
        M1_RVALID =  r_gnt && S_RVALID;
        M0_RLAST  = !r_gnt && S_RLAST;
        M1_RLAST  =  r_gnt && S_RLAST;
      end
      default: ;
    endcase
  end

endmodule
